// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and FSM state type for the data-memory responder.
package dmem_pkg;
  localparam int DEPTH_DEFAULT = 1024;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
  } dmemState_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core-side M-stage memory bus; the core is the master.
interface dmem_responder_if;
  logic memwrite;
  logic memread;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [dmem_pkg::WORD_BYTES-1:0] sel;
  logic [31:0] rdata;
  logic stall;
  logic err;
  modport master(output memwrite, memread, addr, wdata, sel, input rdata, stall, err);
  modport slave(input memwrite, memread, addr, wdata, sel, output rdata, stall, err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 RAM with synchronous read and per-byte write enables.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0] wAddr,
  input  logic [31:0] wData,
  input  logic re,
  input  logic [AW-1:0] rAddr,
  output logic [31:0] q
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (we[i]) mem[wAddr][8*i +: 8] <= wData[8*i +: 8];
    if (re) q <= mem[rAddr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency stores, two-stall-cycle loads, one-cycle err pulse
// on out-of-range, empty-lane, conflicting or mid-load requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  dmemState_t state, stateNext;
  logic [31:0] rdataQ, ramQ;
  logic errQ, errNext, idle, rdStart, highBad;
  logic [AW-1:0] wordIdx;
  assign wordIdx = bus.addr[AW+1:2];
  assign highBad = |bus.addr[31:AW+2];
  assign idle = state == IDLE;
  assign rdStart = idle & bus.memread & ~bus.memwrite;
  // Writes outside IDLE are rejected; a held read in DONE is simply not restarted.
  always_comb begin
    stateNext = idle ? (rdStart ? RD : IDLE) : (state == RD ? DONE : IDLE);
    errNext = idle ? (bus.memwrite ? (highBad | ~|bus.sel | bus.memread) : (bus.memread & highBad))
                   : bus.memwrite;
  end
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) array (
    .clk(clk),
    .we((idle & bus.memwrite & rst) ? bus.sel : '0),
    .wAddr(wordIdx),
    .wData(bus.wdata),
    .re(rdStart & rst),
    .rAddr(wordIdx),
    .q(ramQ)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rdataQ <= '0;
      errQ <= 1'b0;
    end else begin
      state <= stateNext;
      errQ <= errNext;
      if (state == RD) rdataQ <= ramQ;
    end
  end
  assign bus.stall = rst & (rdStart | state == RD);
  assign bus.rdata = rdataQ;
  assign bus.err = errQ;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench; load results are queued at issue
// and compared in the DONE cycle, while every cycle checks stall/err/rdata.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [1024];
  logic [31:0] expQ [$];
  logic [31:0] expRdata = '0;
  dmem_responder_if bus();
  dmem_responder #(.DEPTH(1024), .AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic eStall, input logic eErr, input string tag);
    @(negedge clk);
    bus.memwrite = mw;
    bus.memread = mr;
    bus.addr = a;
    bus.wdata = d;
    bus.sel = s;
    #1;
    chk({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, eStall});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, eErr});
    chk({tag, "_rdata"}, bus.rdata, expRdata);
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic eErr);
    cyc(1'b1, 1'b0, a, d, s, 1'b0, eErr, "st");
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic idleCyc(input logic eErr);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, eErr, "idle");
  endtask
  task automatic load(input logic [31:0] a, input logic e1, input logic e2);
    expQ.push_back(model[a[11:2]]);
    cyc(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b1, e1, "ld_req");
    cyc(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b1, e2, "ld_rd");
    expRdata = expQ.pop_front();
    cyc(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, 1'b0, "ld_done");
  endtask
  initial begin
    bus.memwrite = 1'b0;
    bus.memread = 1'b1;
    bus.addr = '0;
    bus.wdata = '0;
    bus.sel = '0;
    #1;
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_err", {31'd0, bus.err}, 32'd0);
    repeat (2) @(negedge clk);
    bus.memread = 1'b0;
    rst = 1'b1;
    store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    load(32'h10, 1'b0, 1'b0);
    idleCyc(1'b0);
    store(32'h20, 32'h11223344, 4'hF, 1'b0);
    store(32'h20, 32'h000000AA, 4'b0001, 1'b0);
    load(32'h20, 1'b0, 1'b0);
    chk("lane_merge", expRdata, 32'h112233AA);
    idleCyc(1'b0);
    load(32'h10, 1'b0, 1'b0);
    load(32'h20, 1'b0, 1'b0);
    idleCyc(1'b0);
    cyc(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, "conflict");
    model[12] = 32'h5A5A5A5A;
    idleCyc(1'b1);
    load(32'h30, 1'b0, 1'b0);
    idleCyc(1'b0);
    store(32'h10, 32'h0, 4'h0, 1'b0);
    idleCyc(1'b1);
    load(32'h10, 1'b0, 1'b0);
    idleCyc(1'b0);
    expQ.push_back(model[8]);
    cyc(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, "wrd_req");
    cyc(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, "wrd_rd");
    expRdata = expQ.pop_front();
    cyc(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, "wrd_done");
    idleCyc(1'b0);
    load(32'h20, 1'b0, 1'b0);
    idleCyc(1'b0);
    load(32'h00001010, 1'b0, 1'b1);
    chk("wrap_data", expRdata, 32'hDEADBEEF);
    idleCyc(1'b0);
    store(32'h40, 32'h0BADF00D, 4'hF, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, "rst_req");
    @(negedge clk);
    rst = 1'b0;
    expRdata = '0;
    #1;
    chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mid_rdata", bus.rdata, 32'd0);
    chk("rst_mid_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.memread = 1'b0;
    load(32'h40, 1'b0, 1'b0);
    idleCyc(1'b0);
    chk("queue_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 1024, meaning the number of 32-bit words stored.
REQ-002 The block SHALL expose parameter AW, default 10, meaning the word-index width, with log2(DEPTH) = AW.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 memwrite  input  1  core store request, M stage.
REQ-006 memread  input  1  core load request, M stage; held high by the core while stall=1.
REQ-007 addr  input  32  byte address (core aluoutM); bits [1:0] ignored.
REQ-008 wdata  input  32  store data, lane-aligned by the core.
REQ-009 sel  input  4  byte-lane enables; sel[i] covers wdata[8i+7:8i].
REQ-010 rdata  output  32  load data; full word; the core performs lane extraction.
REQ-011 stall  output  1  the core SHALL hold the M/W stages while this is high.
REQ-012 err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-013 Word index SHALL be addr[AW+1:2]; addr[31:AW+2] nonzero SHALL raise err for one cycle, with the access still performed at the wrapped index.
REQ-014 Store: when memwrite=1 in IDLE, lanes with sel[i]=1 SHALL be written at that clock edge; unselected lanes SHALL be unchanged; stall SHALL stay 0 (zero-latency write).
REQ-015 A store with sel=4'b0000 SHALL write nothing and raise err.
REQ-016 FSM states SHALL be IDLE, RD, DONE.
REQ-017 IDLE->RD when memread=1 and memwrite=0; the index is latched and the array read is issued.
REQ-018 RD->DONE unconditionally; the array output is captured into the rdata register at this edge.
REQ-019 DONE->IDLE unconditionally; rdata holds its value until the next load capture.
REQ-020 stall SHALL be combinational: 1 in IDLE when memread=1 and memwrite=0, 1 in RD, and 0 otherwise; total load latency is 2 stall cycles, with data valid in DONE.
REQ-021 In DONE, a still-asserted memread SHALL NOT start a new read; a read asserted in the cycle after DONE SHALL start a new transaction (back-to-back reads take 3 cycles each).
REQ-022 memread=1 and memwrite=1 together SHALL perform the write only, drop the read, keep stall 0, and pulse err.
REQ-023 memwrite asserted in RD or DONE SHALL be ignored and raise err.
REQ-024 A read at an index written in the previous cycle SHALL return the new data (no forwarding hazard, because reads start at least one edge later).

Reset
REQ-025 rst=0 SHALL force state=IDLE, rdata=0, err=0, and stall=0 immediately, including in the middle of RD or DONE; the aborted load SHALL be discarded.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 After rst deasserts, the first request SHALL be serviced from IDLE with no extra delay.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum (IDLE/RD/DONE), DEPTH_DEFAULT=1024, and the WORD_BYTES=4 constant.
REQ-029 The storage SHALL be one sub-module, dmem_array: a synchronous-read, per-byte-write-enable RAM of DEPTH x 32; the FSM, err logic, and rdata register stay in dmem_responder.

Verification
REQ-030 Store addr=0x10, wdata=0xDEADBEEF, sel=4'hF; then load addr=0x10 -> stall high for 2 cycles, rdata=0xDEADBEEF in DONE, err=0.
REQ-031 Store 0x11223344 with sel=F at 0x20, then 0x000000AA with sel=4'b0001 at 0x20; load 0x20 -> 0x112233AA.
REQ-032 Back-to-back loads 0x10 and 0x20 with memread held high -> stall pattern 1,1,0,1,1,0, and each rdata correct in its DONE cycle.
REQ-033 memread=memwrite=1 at 0x30, wdata=0x5A5A5A5A -> stall 0, err pulse; a later load of 0x30 returns 0x5A5A5A5A.
REQ-034 Assert rst=0 during RD -> stall=0 and rdata=0 in the same cycle, state IDLE, and memory contents preserved on a subsequent load.
REQ-035 Load addr=0x00001010 with DEPTH=1024 -> err pulse and data from word index 4 returned.
